my_parity_serial: RTL and testbench

//   Serial parity generator/checker: accumulates WIDTH data bits through a 2-input XOR feedback loop.

---
 rtl/my_parity_serial_pkg.sv | 15 +
 rtl/my_xor2.sv | 10 +
 rtl/my_parity_serial.sv | 99 +++++++++
 tb/tb_my_parity_serial.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_parity_serial_pkg.sv
// Shared types and constants for the serial parity generator/checker.
// State encodings and mode values are kept here so every file agrees on them.
package my_parity_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/my_xor2.sv
// Two-input XOR gate from the basic-gate set.
module my_xor2 (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

// File: rtl/my_parity_serial.sv
// Serial parity generator/checker: folds WIDTH bits through an XOR feedback loop,
// then either reports the parity bit or compares it with a trailing received bit.
module my_parity_serial
    import my_parity_serial_pkg::*;
#(
    parameter int   WIDTH = 8,
    parameter logic ODD   = 1'b0,
    parameter int   CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode,
    input  logic             din,
    input  logic             din_valid,
    output logic             busy,
    output logic             done,
    output logic             parity,
    output logic             error,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

    state_t state_reg;
    logic   acc_reg;
    logic   mode_reg;
    logic   acc_next;

    my_xor2 u_acc_xor (
        .a (acc_reg),
        .b (din),
        .y (acc_next)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            acc_reg   <= 1'b0;
            mode_reg  <= MODE_GEN;
            busy      <= 1'b0;
            done      <= 1'b0;
            parity    <= 1'b0;
            error     <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_SHIFT;
                        busy      <= 1'b1;
                        acc_reg   <= ODD;
                        bit_cnt   <= '0;
                        mode_reg  <= mode;
                        parity    <= 1'b0;
                        error     <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (din_valid) begin
                        acc_reg <= acc_next;
                        if (bit_cnt != WIDTH_C) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (bit_cnt == LAST_C) begin
                            parity <= acc_next;
                            if (mode_reg == MODE_CHK) begin
                                state_reg <= ST_CHECK;
                            end else begin
                                state_reg <= ST_DONE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    // The next valid bit is the received parity, not data.
                    if (din_valid) begin
                        error     <= parity ^ din;
                        state_reg <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_my_parity_serial.sv
// Bench for my_parity_serial: an even and an odd instance share one stimulus stream
// and are compared every cycle against a word-level parity model.
module tb_my_parity_serial;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic mode = 1'b0;
    logic din = 1'b0;
    logic din_valid = 1'b0;

    logic             busy_w   [2];
    logic             done_w   [2];
    logic             parity_w [2];
    logic             error_w  [2];
    logic [CNT_W-1:0] cnt_w    [2];

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            my_parity_serial #(
                .WIDTH (WIDTH),
                .ODD   (1'(gi)),
                .CNT_W (CNT_W)
            ) u_dut (
                .clk       (clk),
                .reset_n   (reset_n),
                .start     (start),
                .mode      (mode),
                .din       (din),
                .din_valid (din_valid),
                .busy      (busy_w[gi]),
                .done      (done_w[gi]),
                .parity    (parity_w[gi]),
                .error     (error_w[gi]),
                .bit_cnt   (cnt_w[gi])
            );
        end
    endgenerate

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Word-level model: collect the data bits, then parity is the XOR-reduction
    // of the collected word (inverted for the odd instance).
    int               m_ph = 0;
    int               m_cnt = 0;
    logic [WIDTH-1:0] m_word = '0;
    logic             m_mode = 1'b0;
    logic             m_busy = 1'b0;
    logic             m_done = 1'b0;
    logic             m_par [2] = '{1'b0, 1'b0};
    logic             m_err [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        if (!reset_n) begin
            m_ph = 0; m_cnt = 0; m_busy = 0; m_done = 0;
            m_par = '{1'b0, 1'b0}; m_err = '{1'b0, 1'b0};
        end else begin
            m_done = 1'b0;
            case (m_ph)
                0: if (start) begin
                    m_ph = 1; m_cnt = 0; m_word = '0; m_mode = mode;
                    m_par = '{1'b0, 1'b0}; m_err = '{1'b0, 1'b0};
                end
                1: if (din_valid) begin
                    m_word[m_cnt] = din;
                    m_cnt++;
                    if (m_cnt == WIDTH) begin
                        m_par[0] = ^m_word;
                        m_par[1] = ~(^m_word);
                        if (m_mode) m_ph = 2;
                        else begin m_ph = 3; m_done = 1'b1; end
                    end
                end
                2: if (din_valid) begin
                    m_err[0] = m_par[0] ^ din;
                    m_err[1] = m_par[1] ^ din;
                    m_ph = 3; m_done = 1'b1;
                end
                default: m_ph = 0;
            endcase
            m_busy = (m_ph == 1) || (m_ph == 2);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("busy%0d", i),   busy_w[i],   m_busy);
                chk($sformatf("done%0d", i),   done_w[i],   m_done);
                chk($sformatf("parity%0d", i), parity_w[i], m_par[i]);
                chk($sformatf("error%0d", i),  error_w[i],  m_err[i]);
                chk($sformatf("bitcnt%0d", i), cnt_w[i],    m_cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_word(input logic m);
        start = 1'b1;
        mode = m;
        tick();
        start = 1'b0;
        mode = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        din = b;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    // Waits (bounded) for done; the edge that samples done must be st+exp_lat.
    task automatic wait_done(input int st, input string nm, input int exp_lat);
        int n = 0;
        while (done_w[0] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk({nm, "_timeout"}, 0, 1);
        else chk(nm, edge_cnt + 1 - st, exp_lat);
    endtask

    // Runs one full word; returns while done is high (state DONE).
    task automatic run_word(input logic m, input logic [7:0] data, input logic pbit,
                            input string nm);
        int st;
        start_word(m);
        st = edge_cnt;
        for (int i = 0; i < WIDTH; i++) send_bit(data[i]);
        if (m) send_bit(pbit);
        wait_done(st, nm, m ? WIDTH + 2 : WIDTH + 1);
    endtask

    initial begin
        int st;
        logic [7:0] w2;
        w2 = 8'b0000_1101;

        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        chk_en = 1'b1;
        tick();
        chk("rst_busy", busy_w[0], 0);
        chk("rst_parity", parity_w[0], 0);
        chk("rst_bitcnt", cnt_w[0], 0);

        // Reset mid-word aborts with no done pulse.
        start_word(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("t1_cnt_pre", cnt_w[0], 3);
        reset_n = 1'b0;
        repeat (3) begin
            tick();
            chk("t1_busy", busy_w[0], 0);
            chk("t1_done", done_w[0], 0);
        end
        chk("t1_cnt", cnt_w[0], 0);
        chk("t1_parity", parity_w[1], 0);
        reset_n = 1'b1;
        tick();
        chk("t1_idle_busy", busy_w[0], 0);

        // Bits 1,0,1,1,0,0,0,0 back-to-back: three ones.
        start_word(1'b0);
        st = edge_cnt;
        for (int i = 0; i < WIDTH; i++) send_bit(w2[i]);
        wait_done(st, "t2_latency", 9);
        chk("t2_par_even", parity_w[0], 1);
        chk("t2_par_odd", parity_w[1], 0);
        chk("t2_err", error_w[0], 0);
        tick();

        run_word(1'b0, 8'hFF, 1'b0, "t3_lat_ff");
        chk("t3_ff_odd", parity_w[1], 1);
        chk("t3_ff_even", parity_w[0], 0);
        tick();
        run_word(1'b0, 8'h00, 1'b0, "t3_lat_00");
        chk("t3_00_odd", parity_w[1], 1);
        tick();
        run_word(1'b0, 8'h01, 1'b0, "t3_lat_01");
        chk("t3_01_odd", parity_w[1], 0);
        chk("t3_01_even", parity_w[0], 1);
        tick();

        run_word(1'b1, 8'h03, 1'b0, "t4_lat_a");
        chk("t4a_err_even", error_w[0], 0);
        chk("t4a_err_odd", error_w[1], 1);
        tick();
        run_word(1'b1, 8'h03, 1'b1, "t4_lat_b");
        chk("t4b_err_even", error_w[0], 1);
        chk("t4b_err_odd", error_w[1], 0);
        repeat (3) tick();
        chk("t4_err_hold", error_w[0], 1);
        chk("t4_par_hold", parity_w[0], 0);

        // Stalls, mid-word start, and din_valid in IDLE.
        start_word(1'b0);
        send_bit(1'b1);
        tick();
        tick();
        chk("t5_cnt_stall", cnt_w[0], 1);
        send_bit(1'b1);
        chk("t5_cnt_2", cnt_w[0], 2);
        start = 1'b1; mode = 1'b1;
        tick();
        start = 1'b0; mode = 1'b0;
        chk("t5_no_restart_cnt", cnt_w[0], 2);
        chk("t5_busy", busy_w[0], 1);
        st = edge_cnt;
        for (int i = 0; i < WIDTH - 2; i++) send_bit(1'b0);
        wait_done(st, "t5_tail", WIDTH - 1);
        chk("t5_par", parity_w[0], 0);
        tick();
        din = 1'b1; din_valid = 1'b1;
        repeat (3) tick();
        din_valid = 1'b0;
        chk("t5_idle_cnt", cnt_w[0], 8);
        chk("t5_idle_par", parity_w[0], 0);
        chk("t5_idle_busy", busy_w[0], 0);

        // start during DONE ignored, next-cycle start accepted and clears outputs.
        run_word(1'b1, 8'h03, 1'b1, "t6_lat");
        start = 1'b1;
        tick();
        chk("t6_done_ignored", busy_w[0], 0);
        chk("t6_err_kept", error_w[0], 1);
        tick();
        start = 1'b0;
        chk("t6_accept_busy", busy_w[0], 1);
        chk("t6_err_clr", error_w[0], 0);
        chk("t6_par_clr_odd", parity_w[1], 0);
        chk("t6_cnt_clr", cnt_w[0], 0);
        st = edge_cnt - 1;
        for (int i = 0; i < WIDTH; i++) send_bit(1'b1);
        wait_done(st, "t6_second", 10);
        chk("t6_par", parity_w[0], 0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
